// File: rtl/pcie_write_dma.sv
// Host-memory write DMA: turns a 64-bit word stream into consecutive aligned
// 8-byte memory-write requests for pcie_tx, with abort and a done pulse.
module pcie_write_dma #(
   parameter int COUNT_W = 20
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [63:0]        start_address,
   input  logic [COUNT_W-1:0] word_count,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [63:0]        in_data,
   output logic               in_ready,
   output logic               write_request_valid,
   output logic [63:0]        write_request_data,
   output logic [63:0]        write_request_address,
   input  logic               write_request_ready,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [COUNT_W-1:0] words_written
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [63:0]        addr_r;
   logic [COUNT_W-1:0] remaining_r;
   logic               valid_r;
   logic [63:0]        data_r;
   logic [63:0]        req_addr_r;
   logic               aborted_r;
   logic [COUNT_W-1:0] words_r;
   logic               in_ready_s;
   logic               accept_s;
   logic               handshake_s;
   logic               start_ok_s;

   // No skid buffer: a new word is taken only when the output slot is free or draining now.
   assign in_ready_s  = (state_r == RUN) && (remaining_r != {COUNT_W{1'b0}}) &&
                        (!valid_r || write_request_ready);
   assign accept_s    = in_valid && in_ready_s;
   assign handshake_s = valid_r && write_request_ready;
   assign start_ok_s  = (state_r == IDLE) && start;

   // Next-state decode for the transfer controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (word_count == {COUNT_W{1'b0}}) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RUN;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (abort || (accept_s && (remaining_r == COUNT_W'(1'b1)))) begin
               state_nxt_s = FLUSH;
            end else begin
               state_nxt_s = RUN;
            end
         end
         FLUSH: begin
            if (!valid_r || write_request_ready) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = FLUSH;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Request slot and address/remaining counters; valid is never retracted before ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_r      <= 64'd0;
         remaining_r <= {COUNT_W{1'b0}};
         valid_r     <= 1'b0;
         data_r      <= 64'd0;
         req_addr_r  <= 64'd0;
      end else if (start_ok_s) begin
         addr_r      <= start_address & ~64'h7;
         remaining_r <= word_count;
      end else if (accept_s) begin
         data_r      <= in_data;
         req_addr_r  <= addr_r;
         valid_r     <= 1'b1;
         addr_r      <= addr_r + 64'd8;
         remaining_r <= remaining_r - COUNT_W'(1'b1);
      end else if (handshake_s) begin
         valid_r     <= 1'b0;
      end
   end

   // Progress and abort status; both survive DONE until the next accepted start.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         words_r   <= {COUNT_W{1'b0}};
         aborted_r <= 1'b0;
      end else if (start_ok_s) begin
         words_r   <= {COUNT_W{1'b0}};
         aborted_r <= 1'b0;
      end else begin
         if (handshake_s) begin
            words_r <= words_r + COUNT_W'(1'b1);
         end
         if ((state_r == RUN) && abort) begin
            aborted_r <= 1'b1;
         end
      end
   end

   assign in_ready              = in_ready_s;
   assign write_request_valid   = valid_r;
   assign write_request_data    = data_r;
   assign write_request_address = req_addr_r;
   assign busy                  = (state_r == RUN) || (state_r == FLUSH);
   assign done                  = (state_r == DONE);
   assign aborted               = aborted_r;
   assign words_written         = words_r;

endmodule

// File: tb/tb_pcie_write_dma.sv
// Directed bench for pcie_write_dma: table of simple transfers plus hand-written
// sequences for backpressure, abort, start-while-busy and mid-transfer reset.
module tb_pcie_write_dma;
   localparam int CW = 20;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [63:0]   start_address;
   logic [CW-1:0] word_count;
   logic          abort;
   logic          in_valid;
   logic [63:0]   in_data;
   logic          in_ready;
   logic          write_request_valid;
   logic [63:0]   write_request_data;
   logic [63:0]   write_request_address;
   logic          write_request_ready;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [CW-1:0] words_written;

   always #5 clock = ~clock;

   pcie_write_dma #(.COUNT_W(CW)) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .start                 (start),
      .start_address         (start_address),
      .word_count            (word_count),
      .abort                 (abort),
      .in_valid              (in_valid),
      .in_data               (in_data),
      .in_ready              (in_ready),
      .write_request_valid   (write_request_valid),
      .write_request_data    (write_request_data),
      .write_request_address (write_request_address),
      .write_request_ready   (write_request_ready),
      .busy                  (busy),
      .done                  (done),
      .aborted               (aborted),
      .words_written         (words_written)
   );

   typedef struct {
      logic [63:0]   addr;
      logic [CW-1:0] cnt;
      logic [63:0]   exp_first;
      int            exp_words;
   } vec_t;

   vec_t        vecs [5];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          acc_cnt = 0;
   int          done_seen = 0;
   int          done_cyc = 0;
   int          last_acc_cyc = 0;
   int          start_cyc = 0;
   int          busy_seen = 0;
   logic [63:0] data_base = 64'd0;
   logic [63:0] obs_addr [$];
   logic [63:0] obs_data [$];
   logic        hold_pend = 1'b0;
   logic [63:0] hold_addr = 64'd0;
   logic [63:0] hold_data = 64'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: observe at the falling edge, drive just after the rising edge.
   task automatic tick();
      @(negedge clock);
      if (hold_pend) begin
         chk("hold_valid", 64'(write_request_valid), 64'd1);
         chk("hold_addr", write_request_address, hold_addr);
         chk("hold_data", write_request_data, hold_data);
      end
      hold_pend = write_request_valid && !write_request_ready;
      hold_addr = write_request_address;
      hold_data = write_request_data;
      if (write_request_valid && write_request_ready) begin
         obs_addr.push_back(write_request_address);
         obs_data.push_back(write_request_data);
      end
      if (in_valid && in_ready) begin
         acc_cnt++;
         last_acc_cyc = cyc;
      end
      if (done) begin
         done_seen++;
         done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      @(posedge clock);
      #1;
      cyc++;
      in_data = data_base + 64'(acc_cnt);
   endtask

   task automatic begin_xfer(input logic [63:0] a, input logic [CW-1:0] n);
      obs_addr.delete();
      obs_data.delete();
      acc_cnt   = 0;
      done_seen = 0;
      busy_seen = 0;
      data_base = 64'hDA7A_0000_0000_0000 + (a << 12);
      in_data   = data_base;
      start_address = a;
      word_count    = n;
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (done_seen == 0 && k < limit) begin
         tick();
         k++;
      end
      checks++;
      if (done_seen == 0) begin
         errors++;
         $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", limit);
      end
   endtask

   task automatic check_stream(input string tag, input logic [63:0] first, input int n);
      chk({tag, "_count"}, 64'(obs_addr.size()), 64'(n));
      for (int i = 0; i < n && i < obs_addr.size(); i++) begin
         chk({tag, "_addr"}, obs_addr[i], first + 64'(8 * i));
         chk({tag, "_data"}, obs_data[i], data_base + 64'(i));
      end
   endtask

   initial begin
      logic [3:0] pat;
      int         k;

      vecs[0] = '{addr: 64'h1000, cnt: 20'd4, exp_first: 64'h1000, exp_words: 4};
      vecs[1] = '{addr: 64'h2005, cnt: 20'd2, exp_first: 64'h2000, exp_words: 2};
      vecs[2] = '{addr: 64'hFFFF_FFFF_FFFF_FFF8, cnt: 20'd2,
                  exp_first: 64'hFFFF_FFFF_FFFF_FFF8, exp_words: 2};
      vecs[3] = '{addr: 64'h7777, cnt: 20'd0, exp_first: 64'h0, exp_words: 0};
      vecs[4] = '{addr: 64'h3007, cnt: 20'd1, exp_first: 64'h3000, exp_words: 1};

      reset_n = 1'b0;
      start = 1'b0;
      start_address = 64'd0;
      word_count = '0;
      abort = 1'b0;
      in_valid = 1'b0;
      in_data = 64'd0;
      write_request_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_valid", 64'(write_request_valid), 64'd0);
      chk("rst_data", write_request_data, 64'd0);
      chk("rst_addr", write_request_address, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      chk("rst_words", 64'(words_written), 64'd0);
      reset_n = 1'b1;
      tick();

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort_aborted", 64'(aborted), 64'd0);
      chk("idle_abort_busy", 64'(busy), 64'd0);

      write_request_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         begin_xfer(vecs[i].addr, vecs[i].cnt);
         wait_done(60);
         check_stream("table", vecs[i].exp_first, vecs[i].exp_words);
         chk("table_words", 64'(words_written), 64'(vecs[i].exp_words));
         chk("table_aborted", 64'(aborted), 64'd0);
         if (vecs[i].exp_words > 0) begin
            chk("table_done_delay", 64'(done_cyc - last_acc_cyc), 64'd2);
         end else begin
            chk("zero_done_delay", 64'(done_cyc - start_cyc), 64'd1);
            chk("zero_busy_seen", 64'(busy_seen), 64'd0);
         end
         repeat (3) tick();
         chk("table_single_done", 64'(done_seen), 64'd1);
         chk("table_words_hold", 64'(words_written), 64'(vecs[i].exp_words));
      end

      // Backpressure 1,0,0,1 with an ignored start in the middle.
      pat = 4'b1001;
      begin_xfer(64'h4000, 20'd3);
      k = 0;
      while (done_seen == 0 && k < 60) begin
         write_request_ready = pat[k % 4];
         if (k == 2) begin
            start_address = 64'h9000;
            word_count    = 20'd5;
            start         = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         k++;
      end
      start = 1'b0;
      chk("toggle_done_seen", 64'(done_seen != 0), 64'd1);
      check_stream("toggle", 64'h4000, 3);
      chk("toggle_words", 64'(words_written), 64'd3);
      write_request_ready = 1'b1;
      tick();

      // Abort after three accepts while pcie_tx stalls.
      begin_xfer(64'h5000, 20'd8);
      k = 0;
      while (acc_cnt < 3 && k < 40) begin
         tick();
         k++;
      end
      write_request_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_in_ready", 64'(in_ready), 64'd0);
         chk("abort_valid_held", 64'(write_request_valid), 64'd1);
         chk("abort_busy", 64'(busy), 64'd1);
         tick();
      end
      write_request_ready = 1'b1;
      wait_done(20);
      check_stream("abort", 64'h5000, 3);
      chk("abort_accepts", 64'(acc_cnt), 64'd3);
      chk("abort_words", 64'(words_written), 64'd3);
      chk("abort_flag", 64'(aborted), 64'd1);
      tick();

      // Reset in the middle of a transfer, then a fresh one-word transfer.
      begin_xfer(64'h6000, 20'd10);
      k = 0;
      while (obs_addr.size() < 5 && k < 40) begin
         tick();
         k++;
      end
      reset_n = 1'b0;
      hold_pend = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(write_request_valid), 64'd0);
      chk("mid_rst_data", write_request_data, 64'd0);
      chk("mid_rst_addr", write_request_address, 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_words", 64'(words_written), 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      begin_xfer(64'h0, 20'd1);
      wait_done(20);
      check_stream("post_rst", 64'h0, 1);
      chk("post_rst_words", 64'(words_written), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
